// File: rtl/icc_time_corr.sv
// Corrected timebase from inter-chassis round-trip results.
// It steps the offset on acquisition and large errors, slews it on small errors, and tracks lock and the fine phase word.
module icc_time_corr #(
  parameter int STEP_THRESH = 64,
  parameter int LOCK_TOL    = 1,
  parameter int LOCK_N      = 4,
  parameter int OUTLIER_N   = 3,
  parameter int SLEW_DIV    = 16
) (
  input  logic        txclk,
  input  logic        sreset,
  input  logic [47:0] txcnt,
  input  logic        stb_diff,
  input  logic [47:0] cdiff2,
  input  logic [15:0] pdiff2,
  output logic [47:0] cnt_corr,
  output logic [47:0] offset_acc,
  output logic [13:0] ph_word,
  output logic        ph_stb,
  output logic        step_stb,
  output logic        slewing,
  output logic        locked,
  output logic [7:0]  reject_cnt
);

  localparam logic [1:0] ST_ACQ   = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_SLEW  = 2'd2;
  localparam int DIV_W = (SLEW_DIV > 2) ? $clog2(SLEW_DIV) : 1;

  logic [1:0]        state_r;
  logic [47:0]       cnt_corr_r;
  logic signed [47:0] offset_acc_r;
  logic signed [47:0] pending_r;
  logic [13:0]       ph_word_r;
  logic              ph_stb_r;
  logic              step_stb_r;
  logic              slewing_r;
  logic              locked_r;
  logic [7:0]        reject_cnt_r;
  logic [7:0]        outcnt_r;
  logic [7:0]        lockcnt_r;
  logic [DIV_W-1:0]  divcnt_r;

  logic signed [47:0] h_s;
  logic [47:0]       habs_s;
  logic              big_s;
  logic              step_s;
  logic              rej_s;
  logic              upd_s;
  logic              tick_s;
  logic signed [47:0] sgn_s;
  logic [7:0]        lock_inc_s;
  logic              unused_s;

  assign h_s        = $signed(cdiff2) >>> 1;
  assign big_s      = habs_s > 48'(STEP_THRESH);
  assign tick_s     = !stb_diff && (state_r == ST_SLEW) && (divcnt_r == DIV_W'(SLEW_DIV - 1));
  assign sgn_s      = pending_r[47] ? -48'sd1 : 48'sd1;
  assign lock_inc_s = (lockcnt_r >= 8'(LOCK_N)) ? lockcnt_r : lockcnt_r + 8'd1;
  assign unused_s   = ^{pdiff2[15], pdiff2[0]};

  // Magnitude of the half-offset, saturating the single unrepresentable value
  always_comb begin
    habs_s = 48'd0;
    if (h_s == 48'sh8000_0000_0000) begin
      habs_s = 48'h7FFF_FFFF_FFFF;
    end else if (h_s[47]) begin
      habs_s = 48'(-h_s);
    end else begin
      habs_s = 48'(h_s);
    end
  end

  // Classify a strobed result as step, outlier reject or in-range update
  always_comb begin
    step_s = 1'b0;
    rej_s  = 1'b0;
    upd_s  = 1'b0;
    if (stb_diff) begin
      case (state_r)
        ST_TRACK, ST_SLEW: begin
          if (big_s) begin
            if (!locked_r || (outcnt_r + 8'd1 >= 8'(OUTLIER_N))) begin
              step_s = 1'b1;
            end else begin
              rej_s = 1'b1;
            end
          end else begin
            upd_s = 1'b1;
          end
        end
        default: step_s = 1'b1;
      endcase
    end else begin
      step_s = 1'b0;
    end
  end

  // Timebase, correction state machine and phase word registers
  always_ff @(posedge txclk) begin
    if (sreset) begin
      state_r      <= ST_ACQ;
      cnt_corr_r   <= 48'd0;
      offset_acc_r <= 48'sd0;
      pending_r    <= 48'sd0;
      ph_word_r    <= 14'd0;
      ph_stb_r     <= 1'b0;
      step_stb_r   <= 1'b0;
      slewing_r    <= 1'b0;
      locked_r     <= 1'b0;
      reject_cnt_r <= 8'd0;
      outcnt_r     <= 8'd0;
      lockcnt_r    <= 8'd0;
      divcnt_r     <= '0;
    end else begin
      cnt_corr_r <= txcnt + offset_acc_r;
      ph_stb_r   <= stb_diff;
      step_stb_r <= step_s;
      if (stb_diff) begin
        ph_word_r <= pdiff2[14:1];
      end
      if (step_s) begin
        offset_acc_r <= offset_acc_r + h_s;
        pending_r    <= 48'sd0;
        slewing_r    <= 1'b0;
        lockcnt_r    <= 8'd0;
        outcnt_r     <= 8'd0;
        locked_r     <= 1'b0;
        divcnt_r     <= '0;
        state_r      <= ST_TRACK;
      end else if (rej_s) begin
        outcnt_r <= outcnt_r + 8'd1;
        if (reject_cnt_r != 8'hFF) begin
          reject_cnt_r <= reject_cnt_r + 8'd1;
        end
      end else if (upd_s) begin
        // A fresh small error replaces whatever slew remainder was outstanding
        outcnt_r  <= 8'd0;
        pending_r <= h_s;
        slewing_r <= (h_s != 48'sd0);
        divcnt_r  <= '0;
        state_r   <= (h_s != 48'sd0) ? ST_SLEW : ST_TRACK;
        if (habs_s <= 48'(LOCK_TOL)) begin
          lockcnt_r <= lock_inc_s;
          if (lock_inc_s >= 8'(LOCK_N)) begin
            locked_r <= 1'b1;
          end
        end else begin
          lockcnt_r <= 8'd0;
        end
      end else if (state_r == ST_SLEW) begin
        if (tick_s) begin
          divcnt_r     <= '0;
          offset_acc_r <= offset_acc_r + sgn_s;
          pending_r    <= pending_r - sgn_s;
          if (pending_r == sgn_s) begin
            slewing_r <= 1'b0;
            state_r   <= ST_TRACK;
          end
        end else begin
          divcnt_r <= divcnt_r + DIV_W'(1);
        end
      end
    end
  end

  assign cnt_corr   = cnt_corr_r;
  assign offset_acc = offset_acc_r;
  assign ph_word    = ph_word_r;
  assign ph_stb     = ph_stb_r;
  assign step_stb   = step_stb_r;
  assign slewing    = slewing_r;
  assign locked     = locked_r;
  assign reject_cnt = reject_cnt_r;

endmodule

// File: tb/tb_icc_time_corr.sv
// Scoreboard bench for icc_time_corr: a cycle model pushes expected outputs per driven cycle,
// a monitor pops and compares them after each edge, plus directed checks on the key scenarios.
module tb_icc_time_corr;

  logic        txclk;
  logic        sreset;
  logic [47:0] txcnt;
  logic        stb_diff;
  logic [47:0] cdiff2;
  logic [15:0] pdiff2;
  logic [47:0] cnt_corr;
  logic [47:0] offset_acc;
  logic [13:0] ph_word;
  logic        ph_stb;
  logic        step_stb;
  logic        slewing;
  logic        locked;
  logic [7:0]  reject_cnt;

  icc_time_corr dut (
    .txclk(txclk), .sreset(sreset), .txcnt(txcnt), .stb_diff(stb_diff),
    .cdiff2(cdiff2), .pdiff2(pdiff2), .cnt_corr(cnt_corr), .offset_acc(offset_acc),
    .ph_word(ph_word), .ph_stb(ph_stb), .step_stb(step_stb), .slewing(slewing),
    .locked(locked), .reject_cnt(reject_cnt)
  );

  typedef struct {
    logic [47:0] corr;
    logic [47:0] off;
    logic [13:0] ph;
    logic        phs;
    logic        stp;
    logic        slw;
    logic        lck;
    logic [7:0]  rej;
  } exp_t;

  exp_t exp_q[$];
  int n_chk  = 0;
  int n_pass = 0;

  // Reference state
  logic signed [47:0] m_off;
  logic signed [47:0] m_pend;
  logic [47:0]        m_corr;
  logic [13:0]        m_ph;
  logic               m_phstb, m_stepstb, m_locked;
  int m_div, m_lock, m_out, m_rej, m_state;  // state: 0 ACQ, 1 TRACK, 2 SLEW
  logic [47:0] tx_base;

  initial begin
    txclk = 1'b0;
    forever #5 txclk = ~txclk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_step();
    logic signed [47:0] h;
    logic [47:0] ah;
    logic [47:0] nx_corr;
    nx_corr = txcnt + m_off;
    if (sreset) begin
      m_off = 0; m_pend = 0; m_corr = 0; m_ph = 0; m_phstb = 0; m_stepstb = 0;
      m_locked = 0; m_div = 0; m_lock = 0; m_out = 0; m_rej = 0; m_state = 0;
    end else begin
      h  = $signed(cdiff2) >>> 1;
      ah = h[47] ? 48'(-h) : 48'(h);
      m_stepstb = 0;
      m_phstb   = 0;
      if (stb_diff) begin
        m_ph = pdiff2[14:1];
        m_phstb = 1;
        if (m_state == 0 || (ah > 64 && (!m_locked || m_out + 1 >= 3))) begin
          m_off = m_off + h; m_pend = 0; m_lock = 0; m_out = 0; m_locked = 0;
          m_div = 0; m_state = 1; m_stepstb = 1;
        end else if (ah > 64) begin
          m_out++;
          if (m_rej < 255) m_rej++;
        end else begin
          m_out = 0; m_pend = h; m_div = 0;
          m_state = (h != 0) ? 2 : 1;
          if (ah <= 1) begin
            if (m_lock < 4) m_lock++;
            if (m_lock >= 4) m_locked = 1;
          end else begin
            m_lock = 0;
          end
        end
      end else if (m_state == 2) begin
        if (m_div == 15) begin
          m_div = 0;
          if (m_pend < 0) begin m_off = m_off - 1; m_pend = m_pend + 1; end
          else begin m_off = m_off + 1; m_pend = m_pend - 1; end
          if (m_pend == 0) m_state = 1;
        end else begin
          m_div++;
        end
      end
      m_corr = nx_corr;
    end
  endtask

  // Drive one cycle at the falling edge, predict its result, then wait past the rising edge
  task automatic cyc(input logic rst, input logic stb, input logic [47:0] c, input logic [15:0] p);
    exp_t e;
    @(negedge txclk);
    sreset = rst; stb_diff = stb; cdiff2 = c; pdiff2 = p;
    txcnt = tx_base;
    tx_base = tx_base + 48'd1;
    model_step();
    e.corr = m_corr; e.off = m_off; e.ph = m_ph; e.phs = m_phstb; e.stp = m_stepstb;
    e.slw = (m_pend != 0); e.lck = m_locked; e.rej = 8'(m_rej);
    exp_q.push_back(e);
    @(posedge txclk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 48'd0, 16'd0);
  endtask

  // Monitor: compare every predicted cycle shortly after the rising edge
  always @(posedge txclk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("cnt_corr",   64'(cnt_corr),   64'(e.corr));
      chk("offset_acc", 64'(offset_acc), 64'(e.off));
      chk("ph_word",    64'(ph_word),    64'(e.ph));
      chk("ph_stb",     64'(ph_stb),     64'(e.phs));
      chk("step_stb",   64'(step_stb),   64'(e.stp));
      chk("slewing",    64'(slewing),    64'(e.slw));
      chk("locked",     64'(locked),     64'(e.lck));
      chk("reject_cnt", 64'(reject_cnt), 64'(e.rej));
    end
  end

  initial begin
    logic [47:0] t_used;
    longint cv;
    int sel;
    sreset = 1'b1; stb_diff = 1'b0; cdiff2 = 48'd0; pdiff2 = 16'd0; txcnt = 48'd0;
    tx_base = 48'h1000;
    m_off = 0; m_pend = 0; m_corr = 0; m_ph = 0; m_phstb = 0; m_stepstb = 0;
    m_locked = 0; m_div = 0; m_lock = 0; m_out = 0; m_rej = 0; m_state = 0;

    // Reset and acquisition
    cyc(1'b1, 1'b0, 48'd0, 16'd0);
    cyc(1'b1, 1'b0, 48'd0, 16'd0);
    chk("rst_offset", 64'(offset_acc), 64'd0);
    chk("rst_corr", 64'(cnt_corr), 64'd0);
    cyc(1'b0, 1'b1, 48'd2000, 16'd0);
    chk("acq_offset", 64'(offset_acc), 64'd1000);
    chk("acq_step", 64'(step_stb), 64'd1);
    t_used = tx_base;
    cyc(1'b0, 1'b0, 48'd0, 16'd0);
    chk("acq_corr", 64'(cnt_corr), 64'(t_used + 48'd1000));
    chk("acq_step_pulse", 64'(step_stb), 64'd0);

    // Slew of -5 at one count per 16 cycles
    cyc(1'b0, 1'b1, -48'sd10, 16'd0);
    chk("slew_start", 64'(slewing), 64'd1);
    idle(79);
    chk("slew_79", 64'(offset_acc), 64'd996);
    chk("slew_79_busy", 64'(slewing), 64'd1);
    idle(1);
    chk("slew_80", 64'(offset_acc), 64'd995);
    chk("slew_done", 64'(slewing), 64'd0);

    // Lock after four in-tolerance results
    cyc(1'b0, 1'b1, 48'd2, 16'd0);
    cyc(1'b0, 1'b1, 48'd0, 16'd0);
    cyc(1'b0, 1'b1, -48'sd2, 16'd0);
    chk("lock_3", 64'(locked), 64'd0);
    cyc(1'b0, 1'b1, 48'd0, 16'd0);
    chk("lock_4", 64'(locked), 64'd1);
    cyc(1'b0, 1'b1, 48'd10, 16'd0);
    chk("lock_hold", 64'(locked), 64'd1);

    // Outlier rejection then step
    cyc(1'b0, 1'b1, 48'd1000, 16'd0);
    cyc(1'b0, 1'b1, 48'd1000, 16'd0);
    chk("rej_cnt", 64'(reject_cnt), 64'd2);
    chk("rej_offset", 64'(offset_acc), 64'd995);
    cyc(1'b0, 1'b1, 48'd1000, 16'd0);
    chk("outl_step", 64'(offset_acc), 64'd1495);
    chk("outl_unlock", 64'(locked), 64'd0);
    chk("outl_stepstb", 64'(step_stb), 64'd1);

    // Slew reversal mid-slew, then reset mid-slew
    cyc(1'b0, 1'b1, -48'sd6, 16'd0);
    idle(5);
    cyc(1'b0, 1'b1, 48'd4, 16'd0);
    idle(15);
    chk("rev_15", 64'(offset_acc), 64'd1495);
    idle(1);
    chk("rev_16", 64'(offset_acc), 64'd1496);
    idle(5);
    cyc(1'b1, 1'b0, 48'd0, 16'd0);
    chk("srst_offset", 64'(offset_acc), 64'd0);
    chk("srst_slew", 64'(slewing), 64'd0);
    chk("srst_rej", 64'(reject_cnt), 64'd0);

    // Phase word and wrap of the corrected count
    cyc(1'b0, 1'b1, -48'sd2, 16'h9001);
    chk("ph_word", 64'(ph_word), 64'h0800);
    chk("ph_stb_on", 64'(ph_stb), 64'd1);
    chk("reacq_step", 64'(step_stb), 64'd1);
    tx_base = 48'd0;
    cyc(1'b0, 1'b0, 48'd0, 16'd0);
    chk("ph_stb_off", 64'(ph_stb), 64'd0);
    chk("wrap_lo", 64'(cnt_corr), 64'hFFFF_FFFF_FFFF);
    cyc(1'b0, 1'b0, 48'd0, 16'd0);
    chk("wrap_hi", 64'(cnt_corr), 64'd0);

    // Random traffic checked by the scoreboard
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 5) cv = longint'($urandom_range(0, 24)) - 64'sd12;
      else if (sel <= 8) cv = ($urandom_range(0, 1) == 0) ? longint'($urandom_range(130, 2000))
                                                          : -longint'($urandom_range(130, 2000));
      else cv = longint'({$urandom(), $urandom()});
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0), 48'(cv), 16'($urandom()));
    end

    // Reject counter saturation
    cyc(1'b1, 1'b0, 48'd0, 16'd0);
    cyc(1'b0, 1'b1, 48'd0, 16'd0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 48'd0, 16'd0);
    for (int i = 0; i < 130; i++) begin
      cyc(1'b0, 1'b1, 48'd1000, 16'd0);
      cyc(1'b0, 1'b1, 48'd1000, 16'd0);
      cyc(1'b0, 1'b1, 48'd0, 16'd0);
    end
    chk("rej_sat", 64'(reject_cnt), 64'd255);
    chk("rej_sat_offset", 64'(offset_acc), 64'd0);
    chk("rej_sat_lock", 64'(locked), 64'd1);

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
